// File: rtl/logic_func_eval.sv
//------------------------------------------------------------------------------
// Module      : logic_func_eval
// Description : Loadable N_IN-input truth-table evaluator with valid/ready
//               single evaluations and an exhaustive minterm sweep.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module logic_func_eval #(
    parameter int N_IN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [2**N_IN-1:0]    cfg_tt,
    input  logic                  in_valid,
    input  logic [N_IN-1:0]       in_x,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_IN-1:0]       out_x,
    output logic                  out_f,
    output logic                  out_last,
    output logic                  done,
    output logic [N_IN:0]         ones_cnt
);

    localparam int            TT_W   = 2**N_IN;
    localparam logic [N_IN-1:0] C_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SWEEP     = 2'd1,
        S_WAIT_LAST = 2'd2
    } state_t;

    state_t              r_state;
    logic [TT_W-1:0]     r_tt;
    logic [N_IN-1:0]     r_cnt;
    logic [N_IN:0]       r_acc;
    logic [N_IN:0]       r_ones;
    logic                r_out_valid;
    logic [N_IN-1:0]     r_out_x;
    logic                r_out_f;
    logic                r_out_last;
    logic                r_done;

    logic                w_free;
    logic                w_sweep_bit;

    assign w_free      = !r_out_valid || out_ready;
    assign w_sweep_bit = r_tt[r_cnt];

    assign in_ready  = (r_state == S_IDLE) && !start && w_free;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_f     = r_out_f;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign ones_cnt  = r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tt        <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ones      <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_f     <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A free slot empties unless something is loaded below.
            if (w_free) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_tt <= cfg_tt;
                    end
                    if (start) begin
                        r_state <= S_SWEEP;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end else if (in_valid && w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_x     <= in_x;
                        r_out_f     <= r_tt[in_x];
                        r_out_last  <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    // Accumulate only on slot load so stalls never double-count.
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_x     <= r_cnt;
                        r_out_f     <= w_sweep_bit;
                        r_out_last  <= (r_cnt == C_LAST);
                        r_acc       <= r_acc + (N_IN+1)'(w_sweep_bit);
                        if (r_cnt == C_LAST) begin
                            r_state <= S_WAIT_LAST;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_LAST: begin
                    if (r_out_valid && out_ready && r_out_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_ones  <= r_acc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
